// File: rtl/adder_ctrl_stage_if.sv
// Request/result handshake bundle for adder_ctrl_stage.
// Signal names keep the original i_/o_ direction prefixes as seen from the stage.
interface adder_ctrl_stage_if #(
  parameter int unsigned bits = 8
);
  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_op;
  logic [bits-1:0] i_a;
  logic [bits-1:0] i_b;
  logic            o_valid;
  logic            i_ready;
  logic [bits-1:0] o_result;
  logic [3:0]      o_flags;

  modport master (
    output i_valid, i_op, i_a, i_b, i_ready,
    input  o_ready, o_valid, o_result, o_flags
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_ready,
    output o_ready, o_valid, o_result, o_flags
  );
endinterface

// File: rtl/adder_ctrl_stage.sv
// Two-stage control wrapper around an external combinational adder:
// S1 holds operands and drives the adder, S2 registers sum and {N,V,Z,C}.
module adder_ctrl_stage #(
  parameter int unsigned bits = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  adder_ctrl_stage_if.slave    bus,
  output logic [bits-1:0]      o_add1,
  output logic [bits-1:0]      o_add2,
  output logic                 o_carry,
  input  logic [bits-1:0]      i_sum,
  input  logic                 i_cout,
  output logic                 o_cflag
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_ADC = 2'b01,
    OP_SUB = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  logic            r_s1_valid;
  logic            r_s2_valid;
  op_e             r_op;
  logic [bits-1:0] r_a;
  logic [bits-1:0] r_b;
  logic [bits-1:0] r_result;
  logic [3:0]      r_flags;
  logic            r_cflag;

  logic            w_ready;
  logic            w_accept;
  logic            w_advance;
  logic            w_drain;
  logic [bits-1:0] w_add2;
  logic            w_carry;
  logic            w_ovf;

  assign w_ready   = !r_s1_valid || !r_s2_valid || bus.i_ready;
  assign w_accept  = bus.i_valid && w_ready;
  assign w_advance = r_s1_valid && (!r_s2_valid || bus.i_ready);
  assign w_drain   = r_s2_valid && bus.i_ready;

  // Carry flag is only written on advance, so the op in S1 always sees its predecessor's carry.
  always_comb begin
    w_add2  = '0;
    w_carry = 1'b0;
    if (r_s1_valid) begin
      unique case (r_op)
        OP_ADD: begin w_add2 = r_b;  w_carry = 1'b0;    end
        OP_ADC: begin w_add2 = r_b;  w_carry = r_cflag; end
        OP_SUB: begin w_add2 = ~r_b; w_carry = 1'b1;    end
        OP_SBC: begin w_add2 = ~r_b; w_carry = r_cflag; end
      endcase
    end
  end

  assign w_ovf = (r_a[bits-1] == w_add2[bits-1]) && (i_sum[bits-1] != r_a[bits-1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_op       <= OP_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_cflag    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_op       <= op_e'(bus.i_op);
        r_a        <= bus.i_a;
        r_b        <= bus.i_b;
      end else if (w_advance) begin
        r_s1_valid <= 1'b0;
      end

      if (w_advance) begin
        r_s2_valid <= 1'b1;
        r_result   <= i_sum;
        r_flags    <= {i_sum[bits-1], w_ovf, (i_sum == '0), i_cout};
        r_cflag    <= i_cout;
      end else if (w_drain) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign bus.o_ready  = w_ready;
  assign bus.o_valid  = r_s2_valid;
  assign bus.o_result = r_result;
  assign bus.o_flags  = r_flags;
  assign o_add1       = r_s1_valid ? r_a : '0;
  assign o_add2       = w_add2;
  assign o_carry      = w_carry;
  assign o_cflag      = r_cflag;

endmodule

// File: tb/tb_adder_ctrl_stage.sv
// Bench for adder_ctrl_stage at bits=8 and bits=16: directed vectors, stall/reset
// sequences and randomized traffic scored against an arithmetic reference model.
module tb_adder_ctrl_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_ctrl_stage_if #(.bits(8))  b8 ();
  adder_ctrl_stage_if #(.bits(16)) b16 ();

  logic [7:0]  add1_8, add2_8, sum8;
  logic        carry8, cout8, cflag8;
  logic [15:0] add1_16, add2_16, sum16;
  logic        carry16, cout16, cflag16;

  assign {cout8, sum8}   = {1'b0, add1_8} + {1'b0, add2_8} + {8'd0, carry8};
  assign {cout16, sum16} = {1'b0, add1_16} + {1'b0, add2_16} + {16'd0, carry16};

  adder_ctrl_stage #(.bits(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b8),
    .o_add1(add1_8), .o_add2(add2_8), .o_carry(carry8),
    .i_sum(sum8), .i_cout(cout8), .o_cflag(cflag8)
  );

  adder_ctrl_stage #(.bits(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b16),
    .o_add1(add1_16), .o_add2(add2_16), .o_carry(carry16),
    .i_sum(sum16), .i_cout(cout16), .o_cflag(cflag16)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  flags;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flags;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q8[$];
  exp_t q16[$];
  logic mc8  = 1'b0;
  logic mc16 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed/unsigned integer arithmetic; flags come from range tests, not bit tricks.
  function automatic exp_t model(input int w, input logic [1:0] op, input logic [15:0] a,
                                 input logic [15:0] b, input logic cin);
    int   lim, ua, ub, sa, sb, ci, t, st, r;
    logic c;
    exp_t e;
    lim = 1 << w;
    ua  = int'(a);
    ub  = int'(b);
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sb  = (ub >= lim / 2) ? ub - lim : ub;
    ci  = (op == 2'b00) ? 0 : (op == 2'b10) ? 1 : int'(cin);
    if (op[1] == 1'b0) begin
      t  = ua + ub + ci;
      st = sa + sb + ci;
      c  = (t >= lim);
    end else begin
      t  = ua - ub - (1 - ci);
      st = sa - sb - (1 - ci);
      c  = (t >= 0);
    end
    r       = ((t % lim) + lim) % lim;
    e.res   = 16'(r);
    e.flags = {(r >= lim / 2), ((st >= lim / 2) || (st < -(lim / 2))), (r == 0), c};
    return e;
  endfunction

  function automatic logic [15:0] rnd_operand(input int w);
    int lim;
    lim = 1 << w;
    case ($urandom_range(0, 4))
      0:       return 16'd0;
      1:       return 16'(lim - 1);
      2:       return 16'(lim / 2);
      default: return 16'($urandom_range(0, lim - 1));
    endcase
  endfunction

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst_n) begin
      q8.delete();
      mc8 = 1'b0;
    end else begin
      chk("ready8", b8.o_ready, !(q8.size() == 2 && !b8.i_ready));
      if (b8.o_valid && b8.i_ready) begin
        if (q8.size() == 0) chk("extra8", q8.size(), 1);
        else begin
          e = q8.pop_front();
          chk("res8", b8.o_result, e.res);
          chk("flags8", b8.o_flags, e.flags);
          chk("cflag8", cflag8, e.flags[0]);
        end
      end
      if (b8.i_valid && b8.o_ready) begin
        e = model(8, b8.i_op, {8'd0, b8.i_a}, {8'd0, b8.i_b}, mc8);
        q8.push_back(e);
        mc8 = e.flags[0];
      end
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst_n) begin
      q16.delete();
      mc16 = 1'b0;
    end else begin
      chk("ready16", b16.o_ready, !(q16.size() == 2 && !b16.i_ready));
      if (b16.o_valid && b16.i_ready) begin
        if (q16.size() == 0) chk("extra16", q16.size(), 1);
        else begin
          e = q16.pop_front();
          chk("res16", b16.o_result, e.res);
          chk("flags16", b16.o_flags, e.flags);
          chk("cflag16", cflag16, e.flags[0]);
        end
      end
      if (b16.i_valid && b16.o_ready) begin
        e = model(16, b16.i_op, b16.i_a, b16.i_b, mc16);
        q16.push_back(e);
        mc16 = e.flags[0];
      end
    end
  end

  task automatic drive8(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    b8.i_valid = v;
    b8.i_op    = op;
    b8.i_a     = a;
    b8.i_b     = b;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    vec_t tbl[10];
    int   t;
    tbl[0] = '{2'b00, 8'h7F, 8'h01, 8'h80, 4'b1100};
    tbl[1] = '{2'b00, 8'hFF, 8'h01, 8'h00, 4'b0011};
    tbl[2] = '{2'b01, 8'h00, 8'h00, 8'h01, 4'b0000};
    tbl[3] = '{2'b10, 8'h05, 8'h07, 8'hFE, 4'b1000};
    tbl[4] = '{2'b11, 8'h10, 8'h01, 8'h0E, 4'b0001};
    tbl[5] = '{2'b10, 8'h80, 8'h01, 8'h7F, 4'b0101};
    tbl[6] = '{2'b01, 8'h00, 8'hFF, 8'h00, 4'b0011};
    tbl[7] = '{2'b11, 8'h00, 8'h00, 8'h00, 4'b0011};
    tbl[8] = '{2'b00, 8'h40, 8'h40, 8'h80, 4'b1100};
    tbl[9] = '{2'b11, 8'h00, 8'h00, 8'hFF, 4'b1000};

    drive8(1'b0, 2'b00, 8'h00, 8'h00);
    b8.i_ready  = 1'b1;
    b16.i_valid = 1'b0;
    b16.i_op    = 2'b00;
    b16.i_a     = '0;
    b16.i_b     = '0;
    b16.i_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_valid", b8.o_valid, 0);
    chk("rst_ready", b8.o_ready, 1);
    chk("rst_result", b8.o_result, 0);
    chk("rst_flags", b8.o_flags, 0);
    chk("rst_cflag", cflag8, 0);
    chk("rst_add1", add1_8, 0);
    chk("rst_add2", add2_8, 0);
    chk("rst_carry", carry8, 0);
    #1 rst_n = 1'b1;

    // Back-to-back vectors: entry j is visible in the result register two edges after it is driven.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (i < 10) drive8(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      else        drive8(1'b0, 2'b00, 8'h00, 8'h00);
      @(negedge clk);
      if (i >= 2) begin
        chk($sformatf("vec%0d_valid", i - 2), b8.o_valid, 1);
        chk($sformatf("vec%0d_res", i - 2), b8.o_result, tbl[i - 2].res);
        chk($sformatf("vec%0d_flags", i - 2), b8.o_flags, tbl[i - 2].flags);
        chk($sformatf("vec%0d_cflag", i - 2), cflag8, tbl[i - 2].flags[0]);
      end
    end
    repeat (2) @(posedge clk);

    // Back-pressure: two ops fill the pipe, the third waits until i_ready returns.
    #1 b8.i_ready = 1'b0;
    drive8(1'b1, 2'b00, 8'h01, 8'h00);
    @(negedge clk); chk("bp_ready_a", b8.o_ready, 1);
    @(posedge clk); #1 drive8(1'b1, 2'b00, 8'h02, 8'h00);
    @(negedge clk); chk("bp_ready_b", b8.o_ready, 1);
    @(posedge clk); #1 drive8(1'b1, 2'b00, 8'h03, 8'h00);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("bp_full_ready", b8.o_ready, 0);
      chk("bp_hold_valid", b8.o_valid, 1);
      chk("bp_hold_res", b8.o_result, 1);
    end
    @(posedge clk); #1 b8.i_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", b8.o_valid, 1);
      chk($sformatf("bp_out%0d", k), b8.o_result, k);
      @(posedge clk); #1;
      if (k == 1) drive8(1'b0, 2'b00, 8'h00, 8'h00);
    end
    @(negedge clk); chk("bp_empty", b8.o_valid, 0);

    // Asynchronous reset with both stages full, carry flag set by the first op.
    @(posedge clk); #1 b8.i_ready = 1'b0;
    drive8(1'b1, 2'b00, 8'hFF, 8'h01);
    @(posedge clk); #1 drive8(1'b1, 2'b00, 8'h01, 8'h01);
    @(posedge clk); #1 drive8(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    chk("ar_full", b8.o_ready, 0);
    chk("ar_cflag_pre", cflag8, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", b8.o_valid, 0);
    chk("ar_cflag", cflag8, 0);
    chk("ar_ready", b8.o_ready, 1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    b8.i_ready = 1'b1;
    @(posedge clk); #1 drive8(1'b1, 2'b01, 8'h05, 8'h03);
    @(posedge clk); #1 drive8(1'b0, 2'b00, 8'h00, 8'h00);
    t = 0;
    @(negedge clk);
    while (!b8.o_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("ar_wait", b8.o_valid, 1);
    chk("ar_res", b8.o_result, 8'h08);
    chk("ar_flags", b8.o_flags, 4'b0000);
    repeat (2) @(posedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      b8.i_valid  = ($urandom_range(0, 3) != 0);
      b8.i_op     = 2'($urandom_range(0, 3));
      b8.i_a      = 8'(rnd_operand(8));
      b8.i_b      = 8'(rnd_operand(8));
      b8.i_ready  = ($urandom_range(0, 3) != 0);
      b16.i_valid = ($urandom_range(0, 3) != 0);
      b16.i_op    = 2'($urandom_range(0, 3));
      b16.i_a     = rnd_operand(16);
      b16.i_b     = rnd_operand(16);
      b16.i_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    b8.i_valid  = 1'b0;
    b8.i_ready  = 1'b1;
    b16.i_valid = 1'b0;
    b16.i_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("drain8", q8.size(), 0);
    chk("drain16", q16.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_ctrl_stage.md
ADDER_CTRL_STAGE -- requirements
Module: adder_ctrl_stage

Interface
REQ-001 Parameter: bits, default 8, operand/result width.
REQ-002 i_clk  in  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_valid  in  1  upstream request valid.
REQ-005 o_ready  out  1  block can accept a request this cycle.
REQ-006 i_op  in  2  00 ADD, 01 ADC, 10 SUB, 11 SBC.
REQ-007 i_a  in  bits  first operand.
REQ-008 i_b  in  bits  second operand.
REQ-009 o_add1  out  bits  operand A to the combinational carry-lookahead adder.
REQ-010 o_add2  out  bits  operand B (or its inverse) to the adder.
REQ-011 o_carry  out  1  carry-in to the adder.
REQ-012 i_sum  in  bits  adder sum, combinational return.
REQ-013 i_cout  in  1  adder carry-out, combinational return.
REQ-014 o_valid  out  1  result valid.
REQ-015 i_ready  in  1  downstream accepts result.
REQ-016 o_result  out  bits  registered sum.
REQ-017 o_flags  out  4  registered {N,V,Z,C} for o_result.
REQ-018 o_cflag  out  1  architectural carry flag register.

Function
REQ-019 Two-stage pipeline: S1 (operand register, drives adder), S2 (result register); each holds one entry with its own valid bit.
REQ-020 Accept when i_valid && o_ready; captures i_op, i_a, i_b into S1.
REQ-021 o_ready = !s1_valid || !s2_valid || i_ready (combinational, no dependency on i_valid).
REQ-022 S1 advances to S2 when s1_valid && (!s2_valid || i_ready); S2 drains when o_valid && i_ready.
REQ-023 S1 refills in the same cycle it advances; full throughput one op/cycle when i_ready=1.
REQ-024 Operand mapping from S1: o_add1 = A; o_add2 = B for ADD/ADC, ~B for SUB/SBC.
REQ-025 o_carry: ADD 0, ADC o_cflag, SUB 1, SBC o_cflag (C=1 means no borrow).
REQ-026 o_add1/o_add2/o_carry are zero when s1_valid=0.
REQ-027 On S1->S2 advance: o_result <= i_sum; C <= i_cout; Z <= (i_sum==0); N <= i_sum[bits-1]; V <= (A[msb]==add2[msb]) && (i_sum[msb]!=A[msb]); o_cflag <= i_cout.
REQ-028 o_cflag updates only on S1->S2 advance, so an ADC/SBC in S1 always sees the carry of the immediately preceding op; back-to-back ADC chains need no stall.
REQ-029 Latency: request accepted at edge k -> o_valid=1 with result after edge k+1 (2 cycles) when not back-pressured.
REQ-030 While o_valid && !i_ready: o_result, o_flags held stable; S1 held; o_ready low iff both stages full.
REQ-031 No entry is dropped or duplicated; results leave in acceptance order.
REQ-032 Width rule: all arithmetic modulo 2^bits; carry-out only via C/o_cflag.

Reset
REQ-033 On i_rst_n=0 (asynchronous): s1_valid=0, s2_valid=0, o_valid=0, o_result=0, o_flags=0, o_cflag=0, S1 operand registers=0.
REQ-034 During and immediately after reset o_ready=1; in-flight entries are discarded, not completed.
REQ-035 Reset release takes effect at the first rising edge with i_rst_n=1; no request accepted while i_rst_n=0.

Verification
REQ-036 ADD 0x7F,0x01, i_ready=1 -> two cycles later o_valid=1, o_result=0x80, N=1 V=1 Z=0 C=0.
REQ-037 ADD 0xFF,0x01 then ADC 0x00,0x00 back-to-back -> 0x00 (Z=1,C=1), then 0x01 (C=0), o_cflag=0 after.
REQ-038 SUB 0x05,0x07 -> 0xFE, C=0, N=1; then SBC 0x10,0x01 -> 0x0E, C=1.
REQ-039 i_ready=0 for 4 cycles with i_valid=1 issuing ops 1..3 -> o_ready falls after two accepted, op1 held stable; on i_ready=1 results emerge 1,2,3 in order, none lost.
REQ-040 Assert i_rst_n=0 with both stages full -> o_valid=0, o_cflag=0 immediately (asynchronous), o_ready=1; next op after release produces correct result with carry-in from cleared flag.
REQ-041 Random ops with random i_valid/i_ready against reference model (bits=8 and bits=16) -> every result and flag matches, ordering preserved.
